// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared AES-128 constants, state enum and byte-level helpers
package aes128_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_RK_W = 1408;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0x00 in the top byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX_TBL[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for rounds 1..10; anything else yields zero
    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// rtl/aes128_key_step.sv - one AES-128 key schedule step (combinational)
module aes128_key_step
    import aes128_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    // RotWord then SubWord on the last word, rcon folded into the leading byte
    assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_encrypt_core.sv
// rtl/aes128_encrypt_core.sv - iterative one-round-per-clock AES-128 encryptor
module aes128_encrypt_core
    import aes128_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plaintext,
    input  logic [127:0]        key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ciphertext,
    output logic [AES_RK_W-1:0] round_keys
);

    aes_state_e          fsm_q, fsm_d;
    logic [127:0]        state_q, state_d;
    logic [127:0]        rk_q, rk_d;
    logic [AES_RK_W-1:0] rkeys_q, rkeys_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [127:0]        next_key;
    logic [7:0]          step_rcon;
    logic [7:0]          sr [16];
    logic [7:0]          mc [16];
    logic [127:0]        round_out;

    assign step_rcon = get_rcon(cnt_q);

    aes128_key_step u_key_step (
        .prev_key (rk_q),
        .rcon     (step_rcon),
        .next_key (next_key)
    );

    // SubBytes+ShiftRows, MixColumns, and the final-round MixColumns bypass
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sr[i] = 8'h00;
            mc[i] = 8'h00;
        end
        round_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sbox(state_q[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            round_out[127-8*i -: 8] = (cnt_q == 4'(AES_NR)) ? sr[i] : mc[i];
        end
    end

    // Next-state logic for the IDLE -> ROUND x10 -> DONE sequence
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_d        = rk_q;
        rkeys_d     = rkeys_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d        = plaintext ^ key;
                    rk_d           = key;
                    rkeys_d[127:0] = key;
                    cnt_d          = 4'd1;
                    in_ready_d     = 1'b0;
                    fsm_d          = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = round_out ^ next_key;
                rk_d    = next_key;
                for (int r = 1; r <= AES_NR; r++) begin
                    if (cnt_q == 4'(r)) rkeys_d[r*128 +: 128] = next_key;
                end
                if (cnt_q == 4'(AES_NR)) begin
                    out_valid_d = 1'b1;
                    fsm_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = ST_IDLE;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            rkeys_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rk_q        <= rk_d;
            rkeys_q     <= rkeys_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = state_q;
    assign round_keys = rkeys_q;

endmodule
